// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF response collector: FSM encoding,
// default parameters and Galois LFSR tap masks.
package puf_pkg;

  localparam int unsigned DefChW     = 8;
  localparam int unsigned DefRespW   = 16;
  localparam int unsigned DefVotes   = 5;
  localparam int unsigned DefSettle  = 4;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StLoad = 3'd1;
  localparam state_t StHigh = 3'd2;
  localparam state_t StLow  = 3'd3;
  localparam state_t StNext = 3'd4;
  localparam state_t StDone = 3'd5;

  // Maximal-length right-shift Galois tap masks per supported challenge width.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       lfsr_taps = 32'h0000_000C;
      8:       lfsr_taps = 32'h0000_00B8;
      16:      lfsr_taps = 32'h0000_B400;
      default: lfsr_taps = 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/puf_challenge_lfsr.sv
// Challenge generator: Galois right-shift LFSR with seed load; a zero seed is
// replaced by 1 so the register can never lock up at all-zeros.
module puf_challenge_lfsr
  import puf_pkg::*;
#(
  parameter int unsigned CH_W = DefChW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iload,
  input  logic            ien,
  input  logic [CH_W-1:0] iseed,
  output logic [CH_W-1:0] ovalue
);

  localparam logic [CH_W-1:0] Taps = CH_W'(lfsr_taps(CH_W));
  localparam logic [CH_W-1:0] One  = CH_W'(1);

  logic [CH_W-1:0] c_q;
  logic [CH_W-1:0] c_d;

  always_comb begin
    c_d = c_q;
    if (iload) begin
      c_d = (iseed == '0) ? One : iseed;
    end else if (ien) begin
      c_d = (c_q >> 1) ^ (c_q[0] ? Taps : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign ovalue = c_q;

endmodule

// File: rtl/puf_response_collector.sv
// Drives challenges and launch pulses into the arbiter PUF, majority-votes the
// synchronized response per challenge and offers the assembled word on valid/ready.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int unsigned CH_W   = DefChW,
  parameter int unsigned RESP_W = DefRespW,
  parameter int unsigned VOTES  = DefVotes,
  parameter int unsigned SETTLE = DefSettle
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   seed,
  output logic [CH_W-1:0]   ochallenge,
  output logic              opulse,
  input  logic              iresponse,
  output logic [RESP_W-1:0] oresp_word,
  output logic              ovalid,
  input  logic              iready,
  output logic              obusy
);

  localparam int unsigned VoteW = $clog2(VOTES + 1);
  localparam int unsigned BitW  = $clog2(RESP_W + 1);
  localparam int unsigned SetW  = $clog2(SETTLE);

  localparam logic [SetW-1:0]  SettleLast = SetW'(SETTLE - 1);
  localparam logic [VoteW-1:0] VotesLast  = VoteW'(VOTES - 1);
  localparam logic [VoteW-1:0] VotesHalf  = VoteW'(VOTES / 2);
  localparam logic [BitW-1:0]  BitsLast   = BitW'(RESP_W - 1);

  state_t              state_q, state_d;
  logic [SetW-1:0]     settle_q, settle_d;
  logic [VoteW-1:0]    votes_q, votes_d;
  logic [VoteW-1:0]    ones_q, ones_d;
  logic [BitW-1:0]     bits_q, bits_d;
  logic [RESP_W-1:0]   word_q, word_d;
  logic [CH_W-1:0]     chal_q, chal_d;
  logic                valid_q, valid_d;
  logic                pulse_q;
  logic                sync1_q, sync2_q;
  logic [CH_W-1:0]     lfsr_value;
  logic                resp_bit;

  puf_challenge_lfsr #(
    .CH_W (CH_W)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .iload  ((state_q == StIdle) && start),
    .ien    (state_q == StNext),
    .iseed  (seed),
    .ovalue (lfsr_value)
  );

  assign resp_bit = (ones_q > VotesHalf);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    votes_d  = votes_q;
    ones_d   = ones_q;
    bits_d   = bits_q;
    word_d   = word_q;
    chal_d   = chal_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          word_d  = '0;
          bits_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        chal_d   = lfsr_value;
        votes_d  = '0;
        ones_d   = '0;
        settle_d = '0;
        state_d  = StHigh;
      end
      StHigh: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          state_d  = StLow;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StLow: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          ones_d   = ones_q + VoteW'(sync2_q);
          votes_d  = votes_q + 1'b1;
          state_d  = (votes_q == VotesLast) ? StNext : StHigh;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StNext: begin
        word_d  = {word_q[RESP_W-2:0], resp_bit};
        bits_d  = bits_q + 1'b1;
        state_d = (bits_q == BitsLast) ? StDone : StLoad;
      end
      StDone: begin
        if (valid_q && iready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Valid is registered, so it rises one cycle into DONE and drops on the handshake edge.
  assign valid_d = (state_q == StDone) && !(valid_q && iready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      settle_q <= '0;
      votes_q  <= '0;
      ones_q   <= '0;
      bits_q   <= '0;
      word_q   <= '0;
      chal_q   <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      votes_q  <= votes_d;
      ones_q   <= ones_d;
      bits_q   <= bits_d;
      word_q   <= word_d;
      chal_q   <= chal_d;
      valid_q  <= valid_d;
      // Pulse lags the HIGH state by a cycle so a fresh challenge settles before launch.
      pulse_q  <= (state_q == StHigh);
      sync1_q  <= iresponse;
      sync2_q  <= sync1_q;
    end
  end

  assign ochallenge = chal_q;
  assign opulse     = pulse_q;
  assign oresp_word = word_q;
  assign ovalid     = valid_q;
  assign obusy      = (state_q != StIdle);

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for puf_response_collector with a behavioural arbiter model
// whose response can be inverted on chosen evaluations of chosen bits.
module tb_puf_response_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  seed;
  logic [7:0]  ochallenge;
  logic        opulse;
  logic        iresponse;
  logic [15:0] oresp_word;
  logic        ovalid;
  logic        iready;
  logic        obusy;

  int total = 0;
  int bad   = 0;

  int          mode;       // 0: response tied high, 1: response = ochallenge[0]
  logic [4:0]  base_inv;   // evaluations inverted on every bit
  logic [4:0]  spec_inv;   // evaluations inverted on bit spec_bit only
  int          spec_bit;
  int          pulse_cnt = 0;
  int          eval_idx  = 0;
  int          bit_idx   = 0;
  logic [7:0]  ch_log [16];
  logic [7:0]  exp_ch [5];

  always #5 clk = ~clk;

  puf_response_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .ochallenge (ochallenge),
    .opulse     (opulse),
    .iresponse  (iresponse),
    .oresp_word (oresp_word),
    .ovalid     (ovalid),
    .iready     (iready),
    .obusy      (obusy)
  );

  always @(posedge opulse) begin
    eval_idx = pulse_cnt % 5;
    bit_idx  = pulse_cnt / 5;
    if (eval_idx == 0 && bit_idx < 16) ch_log[bit_idx] = ochallenge;
    pulse_cnt++;
  end

  always @* begin
    if (mode == 0) iresponse = 1'b1;
    else if (bit_idx == spec_bit) iresponse = ochallenge[0] ^ spec_inv[eval_idx];
    else iresponse = ochallenge[0] ^ base_inv[eval_idx];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] sd);
    @(negedge clk);
    for (int i = 0; i < 16; i++) ch_log[i] = 8'h00;
    pulse_cnt = 0;
    seed  = sd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles from the start edge to ovalid; optionally pulses start at cycle glitch_at.
  task automatic wait_valid(input int glitch_at, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!ovalid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      if (!obusy) busy_ok = 1'b0;
      if (lat == glitch_at) begin
        seed  = 8'h5A;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_word(input string tag, input logic [7:0] sd, input logic [15:0] exp_word);
    int lat;
    bit ok;
    do_start(sd);
    wait_valid(-1, lat, ok);
    check({tag, "_lat"}, lat, 673);
    check({tag, "_word"}, oresp_word, exp_word);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  lat;
    bit  ok;
    bit  held;
    int  n;

    exp_ch[0] = 8'h01; exp_ch[1] = 8'hB8; exp_ch[2] = 8'h5C;
    exp_ch[3] = 8'h2E; exp_ch[4] = 8'h17;
    rst = 1'b1; start = 1'b0; seed = 8'h00; iready = 1'b1;
    mode = 0; base_inv = 5'b0; spec_inv = 5'b0; spec_bit = -1;

    #1;
    check("rst_valid", ovalid, 0);
    check("rst_busy", obusy, 0);
    check("rst_pulse", opulse, 0);
    check("rst_word", oresp_word, 0);
    check("rst_chal", ochallenge, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Response tied high: all-ones word, exact latency, busy throughout.
    do_start(8'h01);
    wait_valid(-1, lat, ok);
    check("t1_lat", lat, 673);
    check("t1_busy", ok, 1);
    check("t1_word", oresp_word, 16'hFFFF);
    @(posedge clk);
    #1;
    check("t1_valid_drop", ovalid, 0);
    check("t1_idle", obusy, 0);

    // Noise-free model: challenge sequence and word.
    mode = 1;
    run_word("t2", 8'h01, 16'h8E25);
    for (int i = 0; i < 5; i++) check($sformatf("t2_ch%0d", i), ch_log[i], exp_ch[i]);
    check("t2_top5", oresp_word[15:11], 5'b10001);

    // Two of five evaluations inverted: votes absorb it.
    base_inv = 5'b01001;
    run_word("t3a", 8'h01, 16'h8E25);
    // Three of five on bit 4 (challenge 17) and on bit 15 (challenge 57).
    spec_bit = 4;  spec_inv = 5'b10101;
    run_word("t3b", 8'h01, 16'h8625);
    spec_bit = 15;
    run_word("t3c", 8'h01, 16'h8E24);
    base_inv = 5'b0; spec_bit = -1;

    // Zero seed substitutes 1; start mid-word ignored.
    do_start(8'h00);
    wait_valid(100, lat, ok);
    check("t4_lat", lat, 673);
    check("t4_ch0", ch_log[0], 8'h01);
    check("t4_word", oresp_word, 16'h8E25);
    @(posedge clk);
    #1;

    // Backpressure in DONE; start pulses there are ignored.
    iready = 1'b0;
    do_start(8'h01);
    wait_valid(-1, lat, ok);
    check("t5_lat", lat, 673);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i % 4 == 0);
      seed  = 8'h00;
      @(posedge clk);
      #1;
      if (!ovalid || oresp_word !== 16'h8E25 || !obusy) held = 1'b0;
    end
    start = 1'b0;
    check("t5_held", held, 1);
    @(negedge clk);
    iready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_valid_drop", ovalid, 0);
    check("t5_idle", obusy, 0);
    @(posedge clk);
    #1;
    check("t5_stay_idle", obusy, 0);

    // Async reset during HIGH of bit 7, then a clean restart.
    do_start(8'h01);
    n = 0;
    while (pulse_cnt < 36 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("t6_reach", pulse_cnt, 36);
    check("t6_partial", oresp_word, 16'h0047);
    rst = 1'b1;
    #1;
    check("t6_pulse", opulse, 0);
    check("t6_valid", ovalid, 0);
    check("t6_word", oresp_word, 0);
    check("t6_busy", obusy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_word("t6r", 8'h01, 16'h8E25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
